// File: rtl/pulse_sched.sv
// pulse_sched: round-robin scheduler sharing one stretched pulse line among CH requesters.
// Trigger pulses are latched as pending. One channel at a time gets a WIDTH-cycle
// pulse tagged with its index, followed by a GAP-cycle low guard interval.
//
// Ports:
//   clk     system clock, rising edge
//   nrst    asynchronous active-low reset
//   en      arbitration enable; low only blocks new grants
//   req     per-channel single-cycle trigger
//   pend    registered pending flags
//   drop    1-cycle flag: request merged into an already-pending one
//   grant   one-hot, high in the first cycle of each output pulse
//   out     stretched output pulse
//   out_id  index of the current or last granted channel
//   busy    high while a pulse or guard interval is in progress
//
// state   | meaning
// S_IDLE  | waiting for an enabled pending request; arbitrates every cycle
// S_PULSE | out high, counting down WIDTH cycles
// S_GUARD | out low, counting down GAP cycles before re-arbitration
module pulse_sched #(
    parameter int CH    = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 1,
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            en,
    input  logic [CH-1:0]   req,
    output logic [CH-1:0]   pend,
    output logic [CH-1:0]   drop,
    output logic [CH-1:0]   grant,
    output logic            out,
    output logic [CH_W-1:0] out_id,
    output logic            busy
);

    localparam int MAXV  = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CNT_W = $clog2(MAXV + 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GUARD} state_t;

    state_t          state_q;
    logic [CH-1:0]   pend_q, pend_d;
    logic [CH-1:0]   drop_q, drop_d;
    logic [CH-1:0]   grant_q;
    logic            out_q;
    logic [CH_W-1:0] out_id_q;
    logic [CH_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic            pick_found;
    logic [CH_W-1:0] pick_idx;
    logic [CH_W:0]   idx_w;
    logic            grant_now;
    logic [CH-1:0]   clr;

    // Search upward from ptr+1, wrapping at CH; the extra index bit holds the sum
    // before the wrap so non-power-of-two CH works too.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx_w      = '0;
        for (int k = 1; k <= CH; k++) begin
            idx_w = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (idx_w >= (CH_W+1)'(CH)) begin
                idx_w = idx_w - (CH_W+1)'(CH);
            end
            if (!pick_found && pend_q[idx_w[CH_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx_w[CH_W-1:0];
            end
        end
    end

    assign grant_now = (state_q == S_IDLE) && en && pick_found;
    assign clr       = grant_now ? (CH'(1) << pick_idx) : '0;

    // A request landing in its own grant cycle re-arms pend instead of merging.
    assign pend_d = req | (pend_q & ~clr);
    assign drop_d = req & pend_q & ~clr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            drop_q   <= '0;
            grant_q  <= '0;
            out_q    <= 1'b0;
            out_id_q <= '0;
            ptr_q    <= CH_W'(CH - 1);
            cnt_q    <= '0;
        end else begin
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            grant_q <= '0;
            case (state_q)
                S_IDLE: begin
                    out_q <= 1'b0;
                    if (grant_now) begin
                        grant_q  <= clr;
                        out_id_q <= pick_idx;
                        ptr_q    <= pick_idx;
                        out_q    <= 1'b1;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        state_q  <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        out_q <= 1'b0;
                        if (GAP > 0) begin
                            cnt_q   <= CNT_W'(GAP - 1);
                            state_q <= S_GUARD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_GUARD: begin
                    out_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    out_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pend   = pend_q;
    assign drop   = drop_q;
    assign grant  = grant_q;
    assign out    = out_q;
    assign out_id = out_id_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_sched.sv
// Testbench for pulse_sched: directed scenarios plus randomized traffic checked
// against a timestamp-based reference model (grant edge, pulse window, next free edge).
module tb_pulse_sched;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int G  = 1;

    logic          clk;
    logic          nrst;
    logic          en;
    logic [CH-1:0] req;
    logic [CH-1:0] pend, drop, grant;
    logic          out_w;
    logic [1:0]    out_id;
    logic          busy;

    logic          en2;
    logic [CH-1:0] req2;
    logic [CH-1:0] pend2, drop2, grant2;
    logic          out2;
    logic [1:0]    out_id2;
    logic          busy2;

    int tests_run;
    int tests_failed;

    pulse_sched #(.CH(CH), .WIDTH(W), .GAP(G)) dut (
        .clk(clk), .nrst(nrst), .en(en), .req(req),
        .pend(pend), .drop(drop), .grant(grant),
        .out(out_w), .out_id(out_id), .busy(busy)
    );

    pulse_sched #(.CH(CH), .WIDTH(1), .GAP(0)) dut2 (
        .clk(clk), .nrst(nrst), .en(en2), .req(req2),
        .pend(pend2), .drop(drop2), .grant(grant2),
        .out(out2), .out_id(out_id2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [CH-1:0] m_pend, m_drop, m_grant;
    logic          m_out, m_busy;
    int            m_out_id, m_last, m_start, m_next_free, ecount;

    task automatic model_reset();
        m_pend      = '0;
        m_drop      = '0;
        m_grant     = '0;
        m_out       = 1'b0;
        m_busy      = 1'b0;
        m_out_id    = 0;
        m_last      = CH - 1;
        m_start     = -1000;
        m_next_free = 0;
    endtask

    function automatic int m_pick();
        for (int k = 1; k <= CH; k++) begin
            int i;
            i = (m_last + k) % CH;
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [CH-1:0] r, input logic e);
        int p;
        logic [CH-1:0] clr;
        p   = -1;
        clr = '0;
        if (ecount >= m_next_free && e && m_pend != '0) begin
            p   = m_pick();
            clr = 4'b0001 << p;
        end
        m_drop  = r & m_pend & ~clr;
        m_pend  = r | (m_pend & ~clr);
        m_grant = clr;
        if (p >= 0) begin
            m_last      = p;
            m_out_id    = p;
            m_start     = ecount;
            m_next_free = ecount + W + G + 1;
        end
        m_out  = (ecount >= m_start) && (ecount < m_start + W);
        m_busy = (ecount >= m_start) && (ecount < m_start + W + G);
        ecount++;
    endtask

    // Drive inputs for one edge, update the model, return at the following negedge.
    task automatic cycle(input logic [CH-1:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        model_edge(r, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req  = '0;
        en   = 1'b0;
        #1 nrst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0;
        req  = '0;
        en   = 1'b0;
        req2 = '0;
        en2  = 1'b0;
        model_reset();
        #12;
        tests_run++;
        if ({pend, drop, grant, out_w, out_id, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pend=%b drop=%b grant=%b out=%b id=%0d busy=%b want all 0",
                     pend, drop, grant, out_w, out_id, busy);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_single();
        cycle(4'b0100, 1'b1);
        tests_run++;
        if (pend !== 4'b0100 || out_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pend: got pend=%b out=%b want pend=0100 out=0", pend, out_w);
        end
        for (int k = 1; k <= W; k++) begin
            cycle(4'b0000, 1'b1);
            tests_run++;
            if (out_w !== 1'b1 || out_id !== 2'd2 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_out c%0d: got out=%b id=%0d busy=%b want 1/2/1", k, out_w, out_id, busy);
            end
            tests_run++;
            if (grant !== ((k == 1) ? 4'b0100 : 4'b0000)) begin
                tests_failed++;
                $display("FAIL single_grant c%0d: got %b", k, grant);
            end
        end
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (out_w !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_guard: got out=%b busy=%b want 0/1", out_w, busy);
        end
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (busy !== 1'b0 || pend !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_idle: got busy=%b pend=%b want 0/0000", busy, pend);
        end
    endtask

    task automatic test_all_req();
        int   order[$];
        int   hi[$];
        int   lo[$];
        int   len;
        logic cur;
        do_reset();
        cycle(4'b1111, 1'b1);
        cur = 1'b0;
        len = 0;
        for (int c = 0; c < 50; c++) begin
            cycle(4'b0000, 1'b1);
            if (grant != '0) begin
                order.push_back($clog2(grant));
                tests_run++;
                if ($countones(pend) != 4 - order.size()) begin
                    tests_failed++;
                    $display("FAIL all_pend_clear g%0d: got pend=%b", order.size(), pend);
                end
            end
            if (out_w === cur) len++;
            else begin
                if (cur) hi.push_back(len);
                else if (order.size() > 1) lo.push_back(len);
                cur = out_w;
                len = 1;
            end
        end
        tests_run++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
            tests_failed++;
            $display("FAIL all_order: got %0d grants %p want 0,1,2,3", order.size(), order);
        end
        tests_run++;
        if (hi.size() != 4 || hi[0] != W || hi[1] != W || hi[2] != W || hi[3] != W) begin
            tests_failed++;
            $display("FAIL all_width: got %p want four of %0d", hi, W);
        end
        tests_run++;
        if (lo.size() != 3 || lo[0] != G + 1 || lo[1] != G + 1 || lo[2] != G + 1) begin
            tests_failed++;
            $display("FAIL all_gap: got %p want three of %0d", lo, G + 1);
        end
    endtask

    task automatic test_fairness();
        int order[$];
        do_reset();
        for (int c = 0; c < 50; c++) begin
            cycle(4'b1001, 1'b1);
            if (grant != '0) order.push_back($clog2(grant));
        end
        tests_run++;
        if (order.size() < 4 || order[0] != 0 || order[1] != 3 || order[2] != 0 || order[3] != 3) begin
            tests_failed++;
            $display("FAIL fairness_order: got %p want 0,3,0,3", order);
        end
    endtask

    task automatic test_merge();
        int n;
        do_reset();
        cycle(4'b0001, 1'b1);
        cycle(4'b0010, 1'b1);
        tests_run++;
        if (grant !== 4'b0001 || drop !== 4'b0000) begin
            tests_failed++;
            $display("FAIL merge_first: got grant=%b drop=%b want 0001/0000", grant, drop);
        end
        cycle(4'b0010, 1'b1);
        tests_run++;
        if (drop !== 4'b0010 || pend !== 4'b0010) begin
            tests_failed++;
            $display("FAIL merge_drop: got drop=%b pend=%b want 0010/0010", drop, pend);
        end
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (drop !== 4'b0000) begin
            tests_failed++;
            $display("FAIL merge_drop_clear: got drop=%b want 0000", drop);
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(4'b0000, 1'b1);
            if (grant === 4'b0010) n++;
        end
        tests_run++;
        if (n != 1) begin
            tests_failed++;
            $display("FAIL merge_one_pulse: got %0d ch1 grants want 1", n);
        end

        do_reset();
        cycle(4'b0100, 1'b1);
        cycle(4'b0100, 1'b1);
        tests_run++;
        if (grant !== 4'b0100 || drop !== 4'b0000 || pend !== 4'b0100) begin
            tests_failed++;
            $display("FAIL rearm_grant_cycle: got grant=%b drop=%b pend=%b want 0100/0000/0100", grant, drop, pend);
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(4'b0000, 1'b1);
            if (grant === 4'b0100) n++;
        end
        tests_run++;
        if (n != 1) begin
            tests_failed++;
            $display("FAIL rearm_second_pulse: got %0d extra ch2 grants want 1", n);
        end
    endtask

    task automatic test_en_gating();
        int hi;
        do_reset();
        cycle(4'b0011, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cycle(4'b0000, 1'b0);
            tests_run++;
            if (out_w !== 1'b0 || grant !== 4'b0000 || pend !== 4'b0011) begin
                tests_failed++;
                $display("FAIL en_hold c%0d: got out=%b grant=%b pend=%b want 0/0000/0011", c, out_w, grant, pend);
            end
        end
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (grant !== 4'b0001 || out_w !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_raise: got grant=%b out=%b want 0001/1", grant, out_w);
        end
        hi = 1;
        for (int c = 0; c < 20; c++) begin
            cycle(4'b0000, 1'b0);
            if (out_w === 1'b1) hi++;
        end
        tests_run++;
        if (hi != W) begin
            tests_failed++;
            $display("FAIL en_complete: got %0d high cycles want %0d", hi, W);
        end
        tests_run++;
        if (pend !== 4'b0010 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_blocked: got pend=%b busy=%b want 0010/0", pend, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(4'b0001, 1'b1);
        cycle(4'b0110, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (out_w !== 1'b1 || pend !== 4'b0110) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got out=%b pend=%b want 1/0110", out_w, pend);
        end
        #2 nrst = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (out_w !== 1'b0 || pend !== 4'b0000 || busy !== 1'b0 || out_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got out=%b pend=%b busy=%b id=%0d want 0", out_w, pend, busy, out_id);
        end
        @(negedge clk);
        nrst = 1'b1;
        cycle(4'b1001, 1'b1);
        cycle(4'b0000, 1'b1);
        tests_run++;
        if (grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rstmid_priority: got grant=%b want 0001", grant);
        end
    endtask

    task automatic test_corner();
        logic exp;
        en2  = 1'b1;
        req2 = 4'b0001;
        cycle(4'b0000, 1'b0);
        tests_run++;
        if (out2 !== 1'b0 || pend2 !== 4'b0001) begin
            tests_failed++;
            $display("FAIL corner_first: got out=%b pend=%b want 0/0001", out2, pend2);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(4'b0000, 1'b0);
            exp = (k % 2 == 0);
            tests_run++;
            if (out2 !== exp || out_id2 !== 2'd0) begin
                tests_failed++;
                $display("FAIL corner_pattern c%0d: got out=%b id=%0d want %b/0", k, out2, out_id2, exp);
            end
        end
        req2 = '0;
        en2  = 1'b0;
    endtask

    task automatic test_random();
        logic [CH-1:0] r;
        logic          e;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            r = CH'($urandom & $urandom);
            e = ($urandom_range(0, 9) != 0);
            cycle(r, e);
            tests_run++;
            if (pend !== m_pend || drop !== m_drop || grant !== m_grant) begin
                tests_failed++;
                $display("FAIL rand_flags c%0d: got pend=%b drop=%b grant=%b want %b/%b/%b",
                         c, pend, drop, grant, m_pend, m_drop, m_grant);
            end
            tests_run++;
            if (out_w !== m_out || busy !== m_busy || out_id !== 2'(m_out_id)) begin
                tests_failed++;
                $display("FAIL rand_out c%0d: got out=%b busy=%b id=%0d want %b/%b/%0d",
                         c, out_w, busy, out_id, m_out, m_busy, m_out_id);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ecount       = 0;
        test_reset();
        test_single();
        test_all_req();
        test_fairness();
        test_merge();
        test_en_gating();
        test_reset_mid();
        test_corner();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
